tb_memory: RTL and testbench
============================

TB_MEMORY -- requirements
Module: tb_memory

Interface
REQ-001 SHALL provide parameter MEM_DEPTH, default 16384, memory size in 32-bit words (64 KiB).
REQ-002 SHALL have port clk  input  1  single clock; all logic updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  synchronous reset, active-high (1 = reset), sampled on clk rising edge.
REQ-004 SHALL have port instr_req  input  1  instruction fetch request.
REQ-005 SHALL have port instr_addr  input  32  fetch byte address.
REQ-006 SHALL have port instr_gnt  output  1  fetch request accepted this cycle.
REQ-007 SHALL have port instr_rdata  output  32  fetched word, qualified by instr_valid.
REQ-008 SHALL have port instr_err  output  1  fetch address out of range, qualified by instr_valid.
REQ-009 SHALL have port instr_valid  output  1  fetch response strobe.
REQ-010 SHALL have port data_req  input  1  load/store request.
REQ-011 SHALL have port data_wr  input  1  1 = store, 0 = load.
REQ-012 SHALL have port data_addr  input  32  load/store byte address.
REQ-013 SHALL have port data_wdata  input  32  store data, little-endian lanes.
REQ-014 SHALL have port data_byteen  input  4  store byte enables; bit i = bits 8i+7:8i.
REQ-015 SHALL have port data_gnt  output  1  data request accepted this cycle.
REQ-016 SHALL have port data_rdata  output  32  load data, qualified by data_valid.
REQ-017 SHALL have port data_valid  output  1  data response strobe (loads and stores).

Function
REQ-018 SHALL hold contents in array named mem, MEM_DEPTH x 32 bits; mem[n] = byte address 4n; array preloadable by hierarchical $readmemh.
REQ-019 SHALL index words by addr[31:2]; addr[1:0] ignored (no misalignment handling).
REQ-020 SHALL drive gnt = req combinationally on each port when reset_n = 0 and no stall (see REQ-029); ports independent, both grantable same cycle.
REQ-021 SHALL assert valid exactly one cycle after a granted request; back-to-back grants give back-to-back valids.
REQ-022 SHALL return mem[index] on rdata with valid for reads; rdata = 0 whenever valid = 0.
REQ-023 SHALL, on a granted store, write only enabled byte lanes at the grant edge; byteen = 0000 writes nothing but still responds; data_rdata = 0 for store responses.
REQ-024 SHALL treat word index >= MEM_DEPTH as out of range: reads return 0, stores ignored; instr_err = 1 with that instr_valid only.
REQ-025 SHALL, for same-cycle store and fetch/load to same word, return pre-store data on the read (read-before-write).

Reset
REQ-026 SHALL while reset_n = 1 drive instr_gnt, instr_valid, instr_err, data_gnt, data_valid = 0 and instr_rdata, data_rdata = 0.
REQ-027 SHALL discard any response pending when reset asserts mid-operation; no valid after reset release without a new grant.
REQ-028 SHALL NOT clear mem on reset; preloaded contents persist.

Configuration
REQ-029 SHALL, with macro TB_MEMORY_WAIT_EN defined, assert valid two cycles after grant and hold that port's gnt low while its response is outstanding (max one outstanding per port); without it, REQ-021 timing applies.

Verification
REQ-030 SHALL cover fetch: mem[0]=32'h00000093, instr_req=1, addr 0 -> gnt same cycle, next cycle instr_valid=1, rdata 00000093, err 0.
REQ-031 SHALL cover byte store: mem[4]=32'h11223344, store addr 0x10 wdata AABBCCDD byteen 0101 -> load addr 0x10 returns 11BB33DD.
REQ-032 SHALL cover out of range: fetch addr 4*MEM_DEPTH -> instr_valid=1, instr_err=1, rdata 0; store there leaves mem unchanged.
REQ-033 SHALL cover collision: store addr 0x8 wdata 12345678 byteen 1111 with fetch addr 0x8 same cycle -> fetch returns old word, later fetch returns 12345678.
REQ-034 SHALL cover reset: pending load when reset_n rises -> no data_valid; all outputs 0 during reset; mem[0] preserved.
REQ-035 SHALL cover TB_MEMORY_WAIT_EN: continuous instr_req -> gnt every other... specifically gnt at cycles 0,2,4 and valid at 2,4,6; without macro gnt every cycle, valid from cycle 1.

Source files
------------

// File: rtl/tb_memory.sv
// rtl/tb_memory.sv - word memory with fetch and load/store ports; TB_MEMORY_WAIT_EN adds a wait state per port
module tb_memory #(
  parameter int MEM_DEPTH = 16384
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic        instr_gnt,
  output logic [31:0] instr_rdata,
  output logic        instr_err,
  output logic        instr_valid,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_byteen,
  output logic        data_gnt,
  output logic [31:0] data_rdata,
  output logic        data_valid
);
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [29:0] DEPTH_W = 30'(MEM_DEPTH);

  logic [31:0] mem [MEM_DEPTH];

  logic             i_stall, d_stall;
  logic             i_fire, d_fire;
  logic             i_in_range, d_in_range;
  logic [IDX_W-1:0] i_idx, d_idx;

  logic        i_cap_valid, i_cap_err, d_cap_valid;
  logic [31:0] i_cap_rdata, d_cap_rdata;
  logic        i_out_valid, i_out_err, d_out_valid;
  logic [31:0] i_out_rdata, d_out_rdata;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{instr_addr[1:0], data_addr[1:0]};

  assign i_in_range = instr_addr[31:2] < DEPTH_W;
  assign d_in_range = data_addr[31:2] < DEPTH_W;
  assign i_idx      = instr_addr[IDX_W+1:2];
  assign d_idx      = data_addr[IDX_W+1:2];

  assign i_fire    = instr_req & ~reset_n & ~i_stall;
  assign d_fire    = data_req & ~reset_n & ~d_stall;
  assign instr_gnt = i_fire;
  assign data_gnt  = d_fire;

  // Contents survive reset so preloaded images stay intact.
  always_ff @(posedge clk) begin
    if (d_fire && data_wr && d_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (data_byteen[b]) mem[d_idx][8*b +: 8] <= data_wdata[8*b +: 8];
      end
    end
  end

  // Reads sample mem at the grant edge, so a same-cycle store is not yet visible.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      i_cap_valid <= 1'b0;
      i_cap_err   <= 1'b0;
      i_cap_rdata <= '0;
      d_cap_valid <= 1'b0;
      d_cap_rdata <= '0;
    end else begin
      i_cap_valid <= i_fire;
      i_cap_err   <= i_fire & ~i_in_range;
      i_cap_rdata <= (i_fire && i_in_range) ? mem[i_idx] : '0;
      d_cap_valid <= d_fire;
      d_cap_rdata <= (d_fire && !data_wr && d_in_range) ? mem[d_idx] : '0;
    end
  end

`ifdef TB_MEMORY_WAIT_EN
  // One extra response stage; a port stays blocked while its request sits in the capture stage.
  assign i_stall = i_cap_valid;
  assign d_stall = d_cap_valid;

  always_ff @(posedge clk) begin
    if (reset_n) begin
      i_out_valid <= 1'b0;
      i_out_err   <= 1'b0;
      i_out_rdata <= '0;
      d_out_valid <= 1'b0;
      d_out_rdata <= '0;
    end else begin
      i_out_valid <= i_cap_valid;
      i_out_err   <= i_cap_err;
      i_out_rdata <= i_cap_rdata;
      d_out_valid <= d_cap_valid;
      d_out_rdata <= d_cap_rdata;
    end
  end
`else
  assign i_stall     = 1'b0;
  assign d_stall     = 1'b0;
  assign i_out_valid = i_cap_valid;
  assign i_out_err   = i_cap_err;
  assign i_out_rdata = i_cap_rdata;
  assign d_out_valid = d_cap_valid;
  assign d_out_rdata = d_cap_rdata;
`endif

  // Outputs are forced quiet for every cycle reset is high, including the first.
  assign instr_valid = i_out_valid & ~reset_n;
  assign instr_err   = i_out_err & instr_valid;
  assign instr_rdata = instr_valid ? i_out_rdata : '0;
  assign data_valid  = d_out_valid & ~reset_n;
  assign data_rdata  = data_valid ? d_out_rdata : '0;

endmodule

// File: tb/tb_tb_memory.sv
// tb/tb_tb_memory.sv - scoreboard bench for tb_memory; build with TB_MEMORY_WAIT_EN for wait-state timing
module tb_tb_memory;
  localparam int DEPTH = 16384;
`ifdef TB_MEMORY_WAIT_EN
  localparam int LAT = 2;
  localparam bit WAIT = 1'b1;
`else
  localparam int LAT = 1;
  localparam bit WAIT = 1'b0;
`endif

  logic        clk, reset_n;
  logic        instr_req, instr_gnt, instr_err, instr_valid;
  logic [31:0] instr_addr, instr_rdata;
  logic        data_req, data_wr, data_gnt, data_valid;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_byteen;

  tb_memory #(.MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_gnt(instr_gnt),
    .instr_rdata(instr_rdata), .instr_err(instr_err), .instr_valid(instr_valid),
    .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_byteen(data_byteen), .data_gnt(data_gnt),
    .data_rdata(data_rdata), .data_valid(data_valid)
  );

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        iq[$], dq[$];
  exp_t        mon_e;
  logic [31:0] model [DEPTH];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  bit          i_prev = 0, d_prev = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return (a >> 2) < 32'(DEPTH);
  endfunction

  function automatic logic [31:0] rd(input logic [31:0] a);
    return in_range(a) ? model[a[31:2]] : 32'h0;
  endfunction

  // One clock of stimulus: drive, predict grants from the protocol rules, queue expected responses.
  task automatic step(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                      input logic [31:0] da, input logic [31:0] wd, input logic [3:0] be);
    bit eig, edg;
    instr_req = ir; instr_addr = ia;
    data_req = dr; data_wr = dw; data_addr = da; data_wdata = wd; data_byteen = be;
    @(negedge clk);
    eig = ir && !reset_n && !(WAIT && i_prev);
    edg = dr && !reset_n && !(WAIT && d_prev);
    check("instr_gnt", 64'(instr_gnt), 64'(eig));
    check("data_gnt", 64'(data_gnt), 64'(edg));
    if (eig) iq.push_back('{cyc + LAT, rd(ia), !in_range(ia)});
    if (edg) begin
      dq.push_back('{cyc + LAT, dw ? 32'h0 : rd(da), 1'b0});
      if (dw && in_range(da))
        for (int b = 0; b < 4; b++)
          if (be[b]) model[da[31:2]][8*b +: 8] = wd[8*b +: 8];
    end
    i_prev = eig;
    d_prev = edg;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 4'h0);
  endtask

  task automatic fetch(input logic [31:0] a);
    step(1, a, 0, 0, 0, 0, 4'h0);
    idle(LAT - 1);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    step(0, 0, 1, 1, a, wd, be);
    idle(LAT - 1);
  endtask

  task automatic load(input logic [31:0] a);
    step(0, 0, 1, 0, a, 0, 4'h0);
    idle(LAT - 1);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 32'(4 * DEPTH) + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
    if (r == 1) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
    if (r == 2) return 32'(4 * (DEPTH - 1)) + 32'($urandom_range(0, 3));
    return 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
  endfunction

  // Monitor: pops an expectation whenever one falls due and compares the presented response.
  always @(negedge clk) begin
    if (reset_n) begin
      check("reset_outputs",
            64'({instr_gnt, instr_valid, instr_err, data_gnt, data_valid, instr_rdata, data_rdata}), 64'h0);
      iq.delete();
      dq.delete();
    end else begin
      if (iq.size() > 0 && iq[0].due == cyc) begin
        mon_e = iq.pop_front();
        check("instr_resp", 64'({instr_valid, instr_err, instr_rdata}), 64'({1'b1, mon_e.err, mon_e.rdata}));
      end else begin
        check("instr_quiet", 64'({instr_valid, instr_err, instr_rdata}), 64'h0);
      end
      if (dq.size() > 0 && dq[0].due == cyc) begin
        mon_e = dq.pop_front();
        check("data_resp", 64'({data_valid, data_rdata}), 64'({1'b1, mon_e.rdata}));
      end else begin
        check("data_quiet", 64'({data_valid, data_rdata}), 64'h0);
      end
    end
  end

  initial begin
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) step(1, 32'h0, 1, 0, 32'h0, 0, 4'h0);
    reset_n = 1'b0;

    for (int w = 0; w < 64; w++) store(32'(w * 4), $urandom, 4'hF);
    store(32'(4 * (DEPTH - 1)), $urandom, 4'hF);

    store(32'h0, 32'h0000_0093, 4'hF);
    fetch(32'h0);

    store(32'h10, 32'h1122_3344, 4'hF);
    store(32'h10, 32'hAABB_CCDD, 4'b0101);
    load(32'h10);
    store(32'h14, 32'h5566_7788, 4'h0);
    load(32'h14);

    fetch(32'(4 * DEPTH));
    store(32'(4 * DEPTH), 32'hDEAD_BEEF, 4'hF);
    load(32'(4 * DEPTH));
    load(32'h0);
    fetch(32'h0);

    step(1, 32'h8, 1, 1, 32'h8, 32'h1234_5678, 4'hF);
    idle(LAT - 1);
    fetch(32'h8);

    idle(2);
    for (int k = 0; k < 6; k++) step(1, 32'(4 * k), 0, 0, 0, 0, 4'h0);
    idle(3);

    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1, rand_addr(), $urandom, 4'($urandom_range(0, 15)));
    idle(3);

    store(32'h0, 32'hCAFE_F00D, 4'hF);
    step(0, 0, 1, 0, 32'h10, 0, 4'h0);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) step(1, 32'h4, 1, 0, 32'h4, 0, 4'h0);
    reset_n = 1'b0;
    idle(4);
    load(32'h0);
    fetch(32'h0);

    idle(LAT + 2);
    check("queues_drained", 64'(iq.size() + dq.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
